// File: rtl/cacheline_mem_responder_pkg.sv
// Shared definitions for the cacheline memory responder: message layouts for
// o=8, abw=32, clw=128, type codes, FSM encoding and line-index width helper.
package cacheline_mem_responder_pkg;

   localparam int unsigned MSG_TYPEW = 3;
   localparam int unsigned MSG_O     = 8;
   localparam int unsigned MSG_ABW   = 32;
   localparam int unsigned MSG_LENW  = 4;
   localparam int unsigned MSG_CLW   = 128;

   localparam logic [MSG_TYPEW-1:0] TYPE_READ  = 3'd0;
   localparam logic [MSG_TYPEW-1:0] TYPE_WRITE = 3'd1;

   // Request, MSB first: type[174:172] opaque[171:164] addr[163:132]
   // len[131:128] data[127:0]  (175 bits)
   typedef struct packed {
      logic [MSG_TYPEW-1:0] typ;
      logic [MSG_O-1:0]     opaque;
      logic [MSG_ABW-1:0]   addr;
      logic [MSG_LENW-1:0]  len;
      logic [MSG_CLW-1:0]   data;
   } mem_req_t;

   // Response, MSB first: type[142:140] opaque[139:132] len[131:128]
   // data[127:0]  (143 bits)
   typedef struct packed {
      logic [MSG_TYPEW-1:0] typ;
      logic [MSG_O-1:0]     opaque;
      logic [MSG_LENW-1:0]  len;
      logic [MSG_CLW-1:0]   data;
   } mem_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Bits needed to index num_lines cachelines (at least one).
   function automatic int idx_nbits(input int num_lines);
      return (num_lines > 1) ? $clog2(num_lines) : 1;
   endfunction

endpackage

// File: rtl/cacheline_mem_array.sv
// Cacheline store: p_num_lines x 128 bits, synchronous clear, combinational
// read, byte-enabled write.
module cacheline_mem_array
   import cacheline_mem_responder_pkg::*;
#(
   parameter int p_num_lines = 64,
   parameter int p_idx_nbits = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [p_idx_nbits-1:0] wr_idx,
   input  logic [15:0]            wr_be,
   input  logic [MSG_CLW-1:0]     wr_data,
   input  logic [p_idx_nbits-1:0] rd_idx,
   output logic [MSG_CLW-1:0]     rd_data
);

   logic [MSG_CLW-1:0] mem_q [p_num_lines];
   logic [MSG_CLW-1:0] line_d;

   assign rd_data = mem_q[rd_idx];

   // Merge enabled write bytes over the current contents of the target line.
   always_comb begin
      line_d = mem_q[wr_idx];
      for (int b = 0; b < 16; b++) begin
         if (wr_be[b]) line_d[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   // Storage update; reset clears every line.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < p_num_lines; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_idx] <= line_d;
      end
   end

endmodule

// File: rtl/cacheline_mem_responder.sv
// Cacheline-wide memory responder: one request at a time, fixed latency.
// Optional macro CACHELINE_MEM_RESPONDER_BYTE_WRITE_EN enables len/offset
// partial writes; without it every write replaces the whole line.
module cacheline_mem_responder
   import cacheline_mem_responder_pkg::*;
#(
   parameter int p_opaque_nbits = 8,
   parameter int p_num_lines    = 64,
   parameter int p_latency      = 2,
   parameter int abw            = 32,
   parameter int clw            = 128
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        memreq_val,
   output logic                                        memreq_rdy,
   input  logic [3+p_opaque_nbits+abw+4+clw-1:0]       memreq_msg,
   output logic                                        memresp_val,
   input  logic                                        memresp_rdy,
   output logic [3+p_opaque_nbits+4+clw-1:0]           memresp_msg,
   input  logic                                        sd
);

   localparam int IDXW  = idx_nbits(p_num_lines);
   localparam int CNT_W = (p_latency > 0) ? $clog2(p_latency + 1) : 1;

   mem_req_t           req;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   mem_resp_t          resp_q, resp_d;
   logic               wr_en;
   logic [15:0]        wr_be;
   logic [MSG_CLW-1:0] wr_data;
   logic [MSG_CLW-1:0] rd_data;
   logic [IDXW-1:0]    idx;
   logic               unused_bits;

   assign req         = memreq_msg;
   assign idx         = req.addr[4 +: IDXW];
   assign memresp_msg = resp_q;
   // sd is a label only; upper address bits wrap and are dropped.
   assign unused_bits = ^{sd, req.addr, req.len};

`ifdef CACHELINE_MEM_RESPONDER_BYTE_WRITE_EN
   // Partial write: len bytes from data[8*len-1:0] placed at addr[3:0];
   // bytes past the end of the line fall off the 16-bit enable.
   always_comb begin
      wr_be   = '1;
      wr_data = req.data;
      if (req.len != '0) begin
         wr_be   = 16'(((32'd1 << req.len) - 32'd1) << req.addr[3:0]);
         wr_data = req.data << {req.addr[3:0], 3'b000};
      end
   end
`else
   assign wr_be   = '1;
   assign wr_data = req.data;
`endif

   cacheline_mem_array #(
      .p_num_lines (p_num_lines),
      .p_idx_nbits (IDXW)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_idx  (idx),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .rd_idx  (idx),
      .rd_data (rd_data)
   );

   // Next state, handshakes, array write strobe and response capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      wr_en       = 1'b0;
      memreq_rdy  = 1'b0;
      memresp_val = 1'b0;
      case (state_q)
         IDLE: begin
            memreq_rdy = 1'b1;
            if (memreq_val) begin
               resp_d.typ    = req.typ;
               resp_d.opaque = req.opaque;
               resp_d.len    = '0;
               resp_d.data   = (req.typ == TYPE_READ) ? rd_data : '0;
               wr_en         = (req.typ == TYPE_WRITE);
               cnt_d         = '0;
               state_d       = (p_latency > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(p_latency - 1)) state_d = RESP;
            else                                cnt_d   = cnt_q + 1'b1;
         end
         RESP: begin
            memresp_val = 1'b1;
            if (memresp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, wait counter and response register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

endmodule

// File: tb/tb_cacheline_mem_responder.sv
// Directed bench for cacheline_mem_responder (latency 2, 64 lines).
module tb_cacheline_mem_responder;

   localparam int LAT = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         memreq_val;
   logic         memreq_rdy;
   logic [174:0] memreq_msg;
   logic         memresp_val;
   logic         memresp_rdy;
   logic [142:0] memresp_msg;
   logic         sd;

   int nchk = 0;
   int nerr = 0;

   localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [127:0] D2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

   cacheline_mem_responder #(
      .p_opaque_nbits (8),
      .p_num_lines    (64),
      .p_latency      (LAT),
      .abw            (32),
      .clw            (128)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memreq_msg  (memreq_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy),
      .memresp_msg (memresp_msg),
      .sd          (sd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [174:0] obs, input logic [174:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [142:0] rsp(input logic [2:0] t, input logic [7:0] op,
                                        input logic [127:0] d);
      return {t, op, 4'd0, d};
   endfunction

   // One complete transaction driven and sampled on negedges.
   task automatic xact(input string tag, input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] a, input logic [3:0] l, input logic [127:0] d,
                       input logic [142:0] exp);
      int lat;
      check({tag, "_req_rdy"}, memreq_rdy, 1'b1);
      memreq_val = 1'b1;
      memreq_msg = {t, op, a, l, d};
      @(negedge clk);
      memreq_val = 1'b0;
      lat = 1;
      while (!memresp_val && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 1 + LAT);
      check({tag, "_msg"}, memresp_msg, exp);
      memresp_rdy = 1'b1;
      @(negedge clk);
      memresp_rdy = 1'b0;
      check({tag, "_rdy_after"}, {memreq_rdy, memresp_val}, 2'b10);
   endtask

   initial begin
      logic seen;
      int   w;
      reset       = 1'b1;
      memreq_val  = 1'b0;
      memreq_msg  = '0;
      memresp_rdy = 1'b0;
      sd          = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("reset_rdy", memreq_rdy, 1'b1);
      check("reset_val", memresp_val, 1'b0);
      check("reset_msg", memresp_msg, 143'd0);

      xact("rd_reset", 3'd0, 8'h80, 32'h0000_0040, 4'd0, '0, rsp(3'd0, 8'h80, '0));
      xact("wr_100",   3'd1, 8'h41, 32'h0000_0100, 4'd0, D1, rsp(3'd1, 8'h41, '0));
      xact("rd_100",   3'd0, 8'hC2, 32'h0000_0100, 4'd0, '0, rsp(3'd0, 8'hC2, D1));
      xact("wr_010",   3'd1, 8'h05, 32'h0000_0010, 4'd0, D2, rsp(3'd1, 8'h05, '0));
      xact("rd_wrap",  3'd0, 8'h06, 32'h0000_0410, 4'd0, '0, rsp(3'd0, 8'h06, D2));
      xact("other",    3'd5, 8'hC3, 32'h0000_0100, 4'd0, D2, rsp(3'd5, 8'hC3, '0));
      xact("rd_keep",  3'd0, 8'h07, 32'h0000_0100, 4'd0, '0, rsp(3'd0, 8'h07, D1));

      // Backpressure: response held for 5 cycles, then accepted.
      memreq_val = 1'b1;
      memreq_msg = {3'd0, 8'h12, 32'h0000_0100, 4'd0, 128'd0};
      @(negedge clk);
      memreq_val = 1'b0;
      w = 0;
      while (!memresp_val && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("bp_arrive", w, LAT);
      for (int i = 0; i < 5; i++) begin
         check("bp_val", memresp_val, 1'b1);
         check("bp_msg", memresp_msg, rsp(3'd0, 8'h12, D1));
         check("bp_req_rdy", memreq_rdy, 1'b0);
         @(negedge clk);
      end
      memresp_rdy = 1'b1;
      check("bp_val6", memresp_val, 1'b1);
      @(negedge clk);
      memresp_rdy = 1'b0;
      check("bp_rdy7", memreq_rdy, 1'b1);

      // Reset one cycle after accepting a read: response must never appear.
      memreq_val = 1'b1;
      memreq_msg = {3'd0, 8'h33, 32'h0000_0100, 4'd0, 128'd0};
      @(negedge clk);
      memreq_val = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_wait_rdy", memreq_rdy, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (memresp_val) seen = 1'b1;
         @(negedge clk);
      end
      check("rst_wait_noresp", seen, 1'b0);
      xact("rd_cleared", 3'd0, 8'h08, 32'h0000_0100, 4'd0, '0, rsp(3'd0, 8'h08, '0));

`ifdef CACHELINE_MEM_RESPONDER_BYTE_WRITE_EN
      xact("bw_fill", 3'd1, 8'h09, 32'h0000_0100, 4'd0, {128{1'b1}}, rsp(3'd1, 8'h09, '0));
      xact("bw_len2", 3'd1, 8'h0A, 32'h0000_010E, 4'd2, 128'hBBAA, rsp(3'd1, 8'h0A, '0));
      xact("bw_rd2",  3'd0, 8'h0B, 32'h0000_0100, 4'd0, '0,
           rsp(3'd0, 8'h0B, {16'hBBAA, {112{1'b1}}}));
      xact("bw_len4", 3'd1, 8'h0C, 32'h0000_010E, 4'd4, 128'h44332211, rsp(3'd1, 8'h0C, '0));
      xact("bw_rd4",  3'd0, 8'h0D, 32'h0000_0100, 4'd0, '0,
           rsp(3'd0, 8'h0D, {16'h2211, {112{1'b1}}}));
      xact("bw_next", 3'd0, 8'h0E, 32'h0000_0110, 4'd0, '0, rsp(3'd0, 8'h0E, '0));
`else
      xact("fw_len2", 3'd1, 8'h0A, 32'h0000_010E, 4'd2, 128'hBBAA, rsp(3'd1, 8'h0A, '0));
      xact("fw_rd",   3'd0, 8'h0B, 32'h0000_0100, 4'd0, '0, rsp(3'd0, 8'h0B, 128'hBBAA));
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
